// File: rtl/branch_trace_driver_if.sv
// Record-load and predictor-side signals of the branch trace driver.
// master = driver side, slave = trace loader plus predictor side.
interface branch_trace_driver_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_ip;
  logic        in_taken;
  logic        pred_en;
  logic [63:0] pred_ip;
  logic        pred_taken;
  logic        pred_prediction;

  modport master (
    input  in_valid, in_ip, in_taken, pred_prediction,
    output in_ready, pred_en, pred_ip, pred_taken
  );

  modport slave (
    output in_valid, in_ip, in_taken, pred_prediction,
    input  in_ready, pred_en, pred_ip, pred_taken
  );
endinterface

// File: rtl/branch_trace_driver.sv
// Buffers (ip, taken) records and replays them into a branch predictor, scoring each prediction.
// Optional macro BTD_LAST_MISS_EN adds capture of the IP of the most recent miss.
//
// state | meaning
// IDLE  | loading records, waiting for start
// RUN   | issuing one buffered record per cycle
// DRAIN | final enable cycle returning the last outcome
// DONE  | one-cycle done pulse
module branch_trace_driver #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  branch_trace_driver_if.master bus,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic [63:0]          last_miss_ip
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT1  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR1  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  SCNT1 = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [63:0]       ip_mem [DEPTH];
  logic [DEPTH-1:0]  taken_mem;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              first_q, first_d;
  logic              cur_taken_q, cur_taken_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pred_en_q, pred_en_d;
  logic [63:0]       pred_ip_q, pred_ip_d;
  logic              pred_taken_q, pred_taken_d;
  logic [CNT_W-1:0]  total_q, hit_q, miss_q;

  logic push, pop, start_ok, clear, score, hit;

  assign push     = bus.in_valid && in_ready_q;
  assign start_ok = start && (state_q == IDLE);
  // pred_taken_q always holds the outcome of the record the predictor is answering for
  assign score    = ((state_q == RUN) && !first_q) || (state_q == DRAIN);
  assign hit      = (bus.pred_prediction == pred_taken_q);

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    clear        = 1'b0;
    first_d      = 1'b0;
    cur_taken_d  = cur_taken_q;
    pred_en_d    = 1'b0;
    pred_ip_d    = '0;
    pred_taken_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          clear = 1'b1;
          if (count_q != '0) begin
            state_d     = RUN;
            pop         = 1'b1;
            pred_en_d   = 1'b1;
            pred_ip_d   = ip_mem[rd_ptr_q];
            cur_taken_d = taken_mem[rd_ptr_q];
            first_d     = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        pred_en_d    = 1'b1;
        pred_taken_d = cur_taken_q;
        if (count_q != '0) begin
          pop         = 1'b1;
          pred_ip_d   = ip_mem[rd_ptr_q];
          cur_taken_d = taken_mem[rd_ptr_q];
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT1;
    else if (pop && !push) count_d = count_q - CNT1;

    in_ready_d = (state_d == IDLE) && (count_d != FULL);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      first_q      <= 1'b0;
      cur_taken_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pred_en_q    <= 1'b0;
      pred_ip_q    <= '0;
      pred_taken_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      first_q      <= first_d;
      cur_taken_q  <= cur_taken_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pred_en_q    <= pred_en_d;
      pred_ip_q    <= pred_ip_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ip_mem[wr_ptr_q]    <= bus.in_ip;
      taken_mem[wr_ptr_q] <= bus.in_taken;
    end
  end

  // Score counters saturate rather than wrap
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      total_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else if (score) begin
      if (total_q != '1) total_q <= total_q + SCNT1;
      if (hit && (hit_q != '1)) hit_q <= hit_q + SCNT1;
      if (!hit && (miss_q != '1)) miss_q <= miss_q + SCNT1;
    end
  end

`ifdef BTD_LAST_MISS_EN
  logic [63:0] prev_ip_q, last_miss_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_ip_q   <= '0;
      last_miss_q <= '0;
    end else begin
      if (state_q == RUN) prev_ip_q <= pred_ip_q;
      if (start_ok) last_miss_q <= '0;
      else if (score && !hit) last_miss_q <= prev_ip_q;
    end
  end

  assign last_miss_ip = last_miss_q;
`else
  assign last_miss_ip = '0;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.pred_en    = pred_en_q;
  assign bus.pred_ip    = pred_ip_q;
  assign bus.pred_taken = pred_taken_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign total_cnt      = total_q;
  assign hit_cnt        = hit_q;
  assign miss_cnt       = miss_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Bench for branch_trace_driver: directed and random runs against a queue-based model,
// with a narrow-counter twin instance fed identical stimulus to check saturation.
module tb_branch_trace_driver;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  branch_trace_driver_if bus ();
  branch_trace_driver_if bus_s ();

  assign bus_s.in_valid        = bus.in_valid;
  assign bus_s.in_ip           = bus.in_ip;
  assign bus_s.in_taken        = bus.in_taken;
  assign bus_s.pred_prediction = bus.pred_prediction;

  logic        busy, done, busy_s, done_s;
  logic [31:0] total_cnt, hit_cnt, miss_cnt;
  logic [1:0]  total_s, hit_s, miss_s;
  logic [63:0] last_miss_ip, last_miss_s;

  branch_trace_driver #(.DEPTH(DEPTH), .ADDR_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .start(start), .busy(busy), .done(done),
    .total_cnt(total_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .last_miss_ip(last_miss_ip)
  );

  branch_trace_driver #(.DEPTH(DEPTH), .ADDR_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s), .start(start), .busy(busy_s), .done(done_s),
    .total_cnt(total_s), .hit_cnt(hit_s), .miss_cnt(miss_s), .last_miss_ip(last_miss_s)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] ipq[$];
  bit          tkq[$];
  longint      exp_total, exp_hit, exp_miss;
  logic [63:0] exp_last_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] sat3(input longint x);
    return (x > 3) ? 64'd3 : 64'(x);
  endfunction

  function automatic logic [63:0] lm_exp();
`ifdef BTD_LAST_MISS_EN
    return exp_last_miss;
`else
    return 64'd0;
`endif
  endfunction

  task automatic check_counts();
    chk("total_cnt", 64'(total_cnt), 64'(exp_total));
    chk("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
    chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    chk("total_sat", 64'(total_s), sat3(exp_total));
    chk("hit_sat", 64'(hit_s), sat3(exp_hit));
    chk("miss_sat", 64'(miss_s), sat3(exp_miss));
    chk("last_miss_ip", last_miss_ip, lm_exp());
    chk("last_miss_ip_s", last_miss_s, lm_exp());
  endtask

  task automatic push_rec(input logic [63:0] ip, input bit t);
    chk("in_ready_load", 64'(bus.in_ready), 64'(ipq.size() < DEPTH));
    bus.in_valid = 1'b1;
    bus.in_ip    = ip;
    bus.in_taken = t;
    tick();
    bus.in_valid = 1'b0;
    if (ipq.size() < DEPTH) begin
      ipq.push_back(ip);
      tkq.push_back(t);
    end
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) push_rec({$urandom, $urandom}, 1'($urandom));
  endtask

  // pmode: 0 = predictor stub tied 0, 1 = tied 1, 2 = random per cycle
  task automatic do_run(input int pmode, input bit noise);
    int n;
    bit p;
    n = ipq.size();
    chk("pred_en_idle", 64'(bus.pred_en), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_total = 0; exp_hit = 0; exp_miss = 0; exp_last_miss = '0;
    if (n > 0) begin
      for (int k = 0; k <= n; k++) begin
        chk("pred_en_run", 64'(bus.pred_en), 64'd1);
        chk("pred_ip", bus.pred_ip, (k < n) ? ipq[k] : 64'd0);
        chk("pred_taken", 64'(bus.pred_taken), (k == 0) ? 64'd0 : 64'(tkq[k-1]));
        chk("busy_run", 64'(busy), 64'd1);
        chk("in_ready_run", 64'(bus.in_ready), 64'd0);
        p = (pmode == 2) ? 1'($urandom) : 1'(pmode);
        bus.pred_prediction = p;
        if (noise) begin
          start        = 1'($urandom);
          bus.in_valid = 1'($urandom);
          bus.in_ip    = {$urandom, $urandom};
          bus.in_taken = 1'($urandom);
        end
        if (k >= 1) begin
          exp_total++;
          if (p == tkq[k-1]) exp_hit++;
          else begin
            exp_miss++;
            exp_last_miss = ipq[k-1];
          end
        end
        tick();
      end
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("pred_en_done", 64'(bus.pred_en), 64'd0);
    chk("busy_done", 64'(busy), 64'd0);
    tick();
    chk("done_clear", 64'(done), 64'd0);
    chk("in_ready_after", 64'(bus.in_ready), 64'd1);
    check_counts();
    ipq.delete();
    tkq.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ip = '0;
    bus.in_taken = 1'b0;
    bus.pred_prediction = 1'b0;
    exp_total = 0; exp_hit = 0; exp_miss = 0; exp_last_miss = '0;

    // reset state
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pred_en", 64'(bus.pred_en), 64'd0);
    chk("rst_pred_ip", bus.pred_ip, 64'd0);
    chk("rst_pred_taken", 64'(bus.pred_taken), 64'd0);
    check_counts();
    reset_n = 1'b1;
    tick();
    chk("in_ready_post_rst", 64'(bus.in_ready), 64'd1);

    // directed four-record run with predictor tied 1
    push_rec(64'h100, 1'b1);
    push_rec(64'h200, 1'b0);
    push_rec(64'h300, 1'b1);
    push_rec(64'h400, 1'b1);
    do_run(1, 1'b0);

    // overfill with in_valid held
    bus.in_valid = 1'b1;
    for (int j = 0; j <= DEPTH; j++) begin
      bus.in_ip    = {$urandom, $urandom};
      bus.in_taken = 1'($urandom);
      chk("in_ready_fill", 64'(bus.in_ready), 64'(j < DEPTH));
      if (j < DEPTH) begin
        ipq.push_back(bus.in_ip);
        tkq.push_back(bus.in_taken);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("in_ready_full", 64'(bus.in_ready), 64'd0);
    do_run(2, 1'b0);

    // empty start
    do_run(2, 1'b0);

    // start and in_valid noise during the run
    load_random(5);
    do_run(2, 1'b1);

    // reset mid-run
    load_random(6);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    ipq.delete();
    tkq.delete();
    exp_total = 0; exp_hit = 0; exp_miss = 0; exp_last_miss = '0;
    chk("midrst_pred_en", 64'(bus.pred_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    check_counts();
    tick();
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    do_run(2, 1'b0);

    // five misses: narrow counters saturate
    for (int i = 0; i < 5; i++) push_rec({$urandom, $urandom}, 1'b1);
    do_run(0, 1'b0);

    // random runs
    for (int r = 0; r < 10; r++) begin
      load_random($urandom_range(0, DEPTH));
      do_run(2, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_trace_driver.md
Name: branch_trace_driver

Overview:
Initiator side of the predictor interface. Buffers a batch of (ip, taken) branch records and, on start, streams them back-to-back into a branch predictor. It honours the predictor's one-cycle-delayed outcome protocol and scores each returned prediction against the recorded outcome. It sits between the trace loader and the predictor in the lab evaluation top level.

Parameters:
DEPTH, 16, record buffer entries; power of 2, minimum 2.
ADDR_W, 4, log2(DEPTH).
CNT_W, 32, width of the score counters.

Ports:
clk  input  1  clock; all logic on posedge.
reset_n  input  1  synchronous active-low reset.
in_valid  input  1  upstream record valid.
in_ready  output  1  buffer accepts a record; a record is taken when in_valid and in_ready are both 1 at a posedge.
in_ip  input  64  record branch IP.
in_taken  input  1  record resolved outcome.
start  input  1  one-cycle pulse that launches a run of all buffered records.
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse after the final comparison.
pred_en  output  1  predictor clock enable; the top level gates the predictor clock with it.
pred_ip  output  64  IP driven to the predictor.
pred_taken  output  1  outcome of the previously issued IP, driven to the predictor.
pred_prediction  input  1  predictor output for the previously issued IP.
total_cnt  output  CNT_W  comparisons made in the last or current run.
hit_cnt  output  CNT_W  predictions equal to the outcome.
miss_cnt  output  CNT_W  predictions not equal to the outcome.
last_miss_ip  output  64  see Optional Feature.

Behaviour:
- Reset (reset_n=0 at a posedge): the following are all 0: FIFO pointers and count, state=IDLE, in_ready, busy, done, pred_en, pred_ip, pred_taken, all counters, last_miss_ip. Reset mid-run aborts the run and discards buffered records.
- All outputs are registered.
- States:
  - IDLE (load): in_ready = (count != DEPTH). A push while full is ignored.
  - start in IDLE with count=N>0: counters clear to 0; go to RUN. start with N=0: go straight to DONE; counters read 0. start outside IDLE is ignored.
- RUN:
  - in_ready=0.
  - Issue cycle i (i=0..N-1): pred_en=1, pred_ip=ip_i, pred_taken=taken_{i-1}. For i=0, pred_taken=0.
  - Records pop in FIFO order, one per cycle, with no bubbles.
  - After issue N-1, go to DRAIN.
- DRAIN: one cycle with pred_en=1, pred_ip=0, pred_taken=taken_{N-1}. Then go to DONE.
- DONE: done=1 for one cycle, pred_en=0, then go to IDLE. Counters hold until the next accepted start.
- Scoring:
  - At the posedge ending issue cycle i≥1, compare pred_prediction against taken_{i-1}.
  - At the posedge ending DRAIN, compare against taken_{N-1}.
  - Exactly N comparisons per run.
  - Each comparison increments total_cnt and exactly one of hit_cnt or miss_cnt.
  - Counters saturate at all-ones with no wrap.
  - The driver keeps a one-deep register of the last issued outcome for pred_taken and scoring.
- pred_en=0 outside RUN/DRAIN, so the predictor never sees idle updates.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by the count register.

Optional Feature:
Macro BTD_LAST_MISS_EN.
- Defined: last_miss_ip captures the IP whose prediction mismatched, at each miss comparison. It clears on accepted start.
- Undefined: last_miss_ip is tied to 0 and no capture register exists.

Test Plan:
- Load 4 records with ip 0x100,0x200,0x300,0x400 and taken 1,0,1,1; stub pred_prediction tied 1; start -> pred_ip sequence 0x100,0x200,0x300,0x400,0; pred_taken 0,1,0,1,1; pred_en high exactly 5 cycles; total=4, hit=3, miss=1; done pulses 1 cycle; with BTD_LAST_MISS_EN, last_miss_ip=0x200.
- Push DEPTH+1 records with in_valid held -> in_ready drops after DEPTH accepts; extra record not stored; run gives total_cnt=DEPTH.
- start with empty buffer -> no pred_en cycle; done pulses the next cycle; all counters 0.
- start pulsed again during RUN, and in_valid asserted during RUN -> both ignored; counts match the single-run values.
- reset_n=0 for one posedge mid-RUN -> pred_en=0 and counters 0 next cycle; state IDLE; buffer empty (in_ready=1).
- CNT_W=2 run of 5 misses (stub tied 0, all taken=1) -> miss_cnt and total_cnt saturate at 3; hit_cnt=0.
